// File: rtl/core_reset_seq_pkg.sv
// core_reset_seq_pkg: shared types and defaults
// for the PLL-driven reset sequencer.
package core_reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    REL_CORE  = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int LOCK_STABLE_CYCLES_DEF = 4800;
  localparam int RELEASE_STAGGER_DEF    = 16;
  localparam int CE_DIV_DEF             = 8;
  localparam int LOSS_CNT_W             = 8;

endpackage

// File: rtl/core_reset_seq_sync_2ff.sv
// sync_2ff: 1-bit two-stage synchronizer,
// async active-high reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // two flops in series to settle metastability
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/core_reset_seq.sv
// core_reset_seq: lock-qualified, staggered video/core resets
// plus 6 MHz enables. Macro CORE_RESET_SEQ_LOSS_CNT_EN adds the loss counter.
module core_reset_seq
  import core_reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int RELEASE_STAGGER    = RELEASE_STAGGER_DEF,
  parameter int CE_DIV             = CE_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  output logic                  video_rst,
  output logic                  core_rst,
  output logic                  ce_6m,
  output logic                  ce_6m_180,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int STAG_W = $clog2(RELEASE_STAGGER + 1);
  localparam int DIV_W  = $clog2(CE_DIV);

  localparam logic [STAB_W-1:0] STAB_MAX =
    STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_MAX =
    STAG_W'(RELEASE_STAGGER - 1);
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF =
    DIV_W'(CE_DIV / 2);

  logic              locked_s;
  state_e            state_q;
  logic [STAB_W-1:0] stab_q;
  logic [STAG_W-1:0] stag_q;
  logic              video_rst_q;
  logic              video_rst_d;
  logic              core_rst_q;
  logic              ready_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic              ce_q;
  logic              ce180_q;

  sync_2ff u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // next video reset: released after the stable window,
  // re-asserted by any loss of lock once released
  always_comb begin
    video_rst_d = 1'b1;
    div_d       = '0;
    if (state_q == WAIT_LOCK) begin
      video_rst_d = !(locked_s && (stab_q == STAB_MAX));
    end else begin
      video_rst_d = !locked_s;
    end
    if (!video_rst_q) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    end
  end

  // sequencing FSM with registered reset outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      stab_q      <= '0;
      stag_q      <= '0;
      video_rst_q <= 1'b1;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      video_rst_q <= video_rst_d;
      unique case (state_q)
        WAIT_LOCK: begin
          if (!locked_s) begin
            stab_q <= '0;
          end else if (stab_q == STAB_MAX) begin
            stab_q  <= '0;
            stag_q  <= '0;
            state_q <= REL_CORE;
          end else begin
            stab_q <= stab_q + 1'b1;
          end
        end
        REL_CORE: begin
          if (!locked_s) begin
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            stab_q     <= '0;
            state_q    <= WAIT_LOCK;
          end else if (stag_q == STAG_MAX) begin
            core_rst_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= RUN;
          end else begin
            stag_q <= stag_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            stab_q     <= '0;
            state_q    <= WAIT_LOCK;
          end else if (soft_reset_req) begin
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            stag_q     <= '0;
            state_q    <= REL_CORE;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  // enable divider: phase 0 lands on the first released cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      ce_q    <= 1'b0;
      ce180_q <= 1'b0;
    end else if (video_rst_d) begin
      div_q   <= '0;
      ce_q    <= 1'b0;
      ce180_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      ce_q    <= (div_d == '0);
      ce180_q <= (div_d == DIV_HALF);
    end
  end

`ifdef CORE_RESET_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;
  logic                  loss_evt;

  assign loss_evt = (state_q != WAIT_LOCK) && !locked_s;

  // saturating count of lock losses after a release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != '1)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

  assign video_rst = video_rst_q;
  assign core_rst  = core_rst_q;
  assign ready     = ready_q;
  assign ce_6m     = ce_q;
  assign ce_6m_180 = ce180_q;

endmodule

// File: tb/tb_core_reset_seq.sv
// tb_core_reset_seq: scoreboard bench; a timeline model
// predicts every cycle's outputs, a monitor compares them.
module tb_core_reset_seq;

  localparam int L  = 16;
  localparam int S  = 4;
  localparam int CE = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       video_rst;
  logic       core_rst;
  logic       ce_6m;
  logic       ce_6m_180;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  typedef struct packed {
    logic       v;
    logic       c;
    logic       r;
    logic       ce;
    logic       ce180;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  // timeline model state
  int edge_n   = 0;
  bit p1       = 0;
  bit p2       = 0;
  int run_len  = 0;
  bit vup      = 0;
  bit cup      = 0;
  int t_v      = 0;
  int core_due = 0;
  int loss     = 0;

  core_reset_seq #(
    .LOCK_STABLE_CYCLES (L),
    .RELEASE_STAGGER    (S),
    .CE_DIV             (CE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .video_rst      (video_rst),
    .core_rst       (core_rst),
    .ce_6m          (ce_6m),
    .ce_6m_180      (ce_6m_180),
    .ready          (ready),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {video_rst, core_rst, ready,
            ce_6m, ce_6m_180, lock_loss_cnt};
  endfunction

  task automatic chk(input string name,
                     input logic [12:0] act,
                     input logic [12:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %b required %b",
               name, $time, act, req);
    end
  endtask

  // reference: outputs after one edge, from release times
  task automatic model_edge(input bit pl, input bit sr,
                            input bit r);
    bit   ls;
    exp_t e;
    edge_n++;
    if (r) begin
      p1 = 0; p2 = 0; run_len = 0;
      vup = 0; cup = 0; loss = 0;
    end else begin
      ls = p2; p2 = p1; p1 = pl;
      if (!vup) begin
        if (ls) begin
          run_len++;
          if (run_len == L) begin
            vup = 1; cup = 0; run_len = 0;
            t_v = edge_n;
            core_due = edge_n + S;
          end
        end else begin
          run_len = 0;
        end
      end else if (!ls) begin
        vup = 0; cup = 0; run_len = 0;
        if (loss < 255) loss++;
      end else if (cup) begin
        if (sr) begin
          cup = 0;
          core_due = edge_n + S;
        end
      end else if (edge_n == core_due) begin
        cup = 1;
      end
    end
    e.v     = !vup;
    e.c     = !cup;
    e.r     = cup;
    e.ce    = vup && ((edge_n - t_v) % CE == 0);
    e.ce180 = vup && ((edge_n - t_v) % CE == CE / 2);
`ifdef CORE_RESET_SEQ_LOSS_CNT_EN
    e.cnt = 8'(loss);
`else
    e.cnt = 8'd0;
`endif
    exp_q.push_back(e);
  endtask

  // drive one cycle of inputs and predict its edge
  task automatic step(input bit pl, input bit sr,
                      input bit r);
    @(negedge clk);
    pll_locked     = pl;
    soft_reset_req = sr;
    rst            = r;
    if (r) begin
      #1;
      chk("async_rst_now", outs(), 13'b1_1000_0000_0000);
    end
    model_edge(pl, sr, r);
  endtask

  task automatic at_edge(input string name,
                         input logic [12:0] mask,
                         input logic [12:0] req);
    @(posedge clk);
    #1;
    chk(name, outs() & mask, req & mask);
  endtask

  // monitor: compare each presented cycle with the scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("cycle_outputs", outs(), mon_e);
      if (ce_6m || ce_6m_180)
        chk("ce_exclusive", {12'd0, ce_6m & ce_6m_180}, 13'd0);
    end
  end

  localparam logic [12:0] M_V  = 13'b1_0000_0000_0000;
  localparam logic [12:0] M_C  = 13'b0_1000_0000_0000;
  localparam logic [12:0] M_R  = 13'b0_0100_0000_0000;
  localparam logic [12:0] M_CE = 13'b0_0010_0000_0000;

  initial begin
    rst = 1; pll_locked = 0; soft_reset_req = 0;
    step(0, 0, 1);
    step(0, 0, 1);

    // 1: clean lock from edge 0
    for (int i = 0; i <= 16; i++) step(1, 0, 0);
    at_edge("t1_vid_edge16", M_V, M_V);
    step(1, 0, 0);
    at_edge("t1_edge17", M_V | M_C | M_CE, M_C | M_CE);
    for (int i = 18; i <= 20; i++) step(1, 0, 0);
    at_edge("t1_core_edge20", M_C | M_R, M_C);
    step(1, 0, 0);
    at_edge("t1_core_edge21", M_C | M_R, M_R);
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // 2: glitch in the stable window
    step(0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0);

    // 3: loss in RUN, relock
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0);

    // 4: soft reset in RUN, then 5: 64-cycle enable run
    step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0);
    for (int i = 0; i < 64; i++) step(1, 0, 0);

    // 6a: async reset in REL_CORE
    step(0, 0, 1);
    for (int i = 0; i < L + 3; i++) step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);

    // random traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom % 40) != 0,
           ($urandom % 16) == 0,
           ($urandom % 600) == 0);

    // 6b: 300 lock losses to saturate the counter
    step(0, 0, 1);
    for (int k = 0; k < 300; k++) begin
      repeat (L + 2 + $urandom_range(0, 3)) step(1, 0, 0);
      repeat (3) step(0, 0, 0);
    end
    @(posedge clk);
    #1;
`ifdef CORE_RESET_SEQ_LOSS_CNT_EN
    chk("loss_cnt_sat", {5'd0, lock_loss_cnt}, 13'd255);
`else
    chk("loss_cnt_zero", {5'd0, lock_loss_cnt}, 13'd0);
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 13'(exp_q.size()), 13'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
